// File: rtl/pool_result_streamer.sv
// Streams the finished pooled image from the pooler BRAM read port to the UART TX, one byte per handshake.
// Optional: define STREAM_CHECKSUM_EN to append an 8-bit XOR checksum byte after the last pixel.
module pool_result_streamer #(
    parameter int OUTSIZE = 3969,
    parameter int AW      = 16,
    parameter int RD_LAT  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pool_done,
    output logic [AW-1:0] infer_addr,
    input  logic [7:0]    infer_dout,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          stream_busy,
    output logic          stream_done,
    output logic [AW-1:0] byte_count
);

    localparam int LW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(OUTSIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_RDWAIT,
        S_WAIT_TX,
        S_GUARD,
        S_DRAIN,
        S_NEXT,
`ifdef STREAM_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   lat_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;
    logic            busy_q;
    logic            done_q;
    logic [AW-1:0]   count_q;
`ifdef STREAM_CHECKSUM_EN
    logic [7:0]      csum_q;
    logic            csum_phase_q;
`endif

    // Losing pool_done while a frame is in flight abandons the frame at once.
    logic abort;
    assign abort = !pool_done && (state_q != S_IDLE) && (state_q != S_DONE);

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            lat_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
`ifdef STREAM_CHECKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                addr_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pool_done) begin
                            count_q      <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= S_ADDR;
`ifdef STREAM_CHECKSUM_EN
                            csum_q       <= '0;
                            csum_phase_q <= 1'b0;
`endif
                        end
                    end
                    S_ADDR: begin
                        lat_q   <= LW'(RD_LAT - 1);
                        state_q <= S_RDWAIT;
                    end
                    S_RDWAIT: begin
                        // The address has been on the port since ADDR, so data is ready after RD_LAT-1 more cycles.
                        lat_q <= (lat_q == '0) ? '0 : lat_q - 1'b1;
                        if (lat_q <= LW'(1)) begin
                            tx_data_q <= infer_dout;
`ifdef STREAM_CHECKSUM_EN
                            csum_q    <= csum_q ^ infer_dout;
`endif
                            state_q   <= S_WAIT_TX;
                        end
                    end
                    S_WAIT_TX: begin
                        if (!tx_busy) begin
                            tx_start_q <= 1'b1;
                            count_q    <= count_q + 1'b1;
                            state_q    <= S_GUARD;
                        end
                    end
                    S_GUARD: state_q <= S_DRAIN;
                    S_DRAIN: begin
                        if (!tx_busy) begin
`ifdef STREAM_CHECKSUM_EN
                            if (csum_phase_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_NEXT;
                            end
`else
                            state_q <= S_NEXT;
`endif
                        end
                    end
                    S_NEXT: begin
                        if (addr_q == LAST_ADDR) begin
`ifdef STREAM_CHECKSUM_EN
                            state_q <= S_CSUM;
`else
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= S_ADDR;
                        end
                    end
`ifdef STREAM_CHECKSUM_EN
                    S_CSUM: begin
                        tx_data_q    <= csum_q;
                        csum_phase_q <= 1'b1;
                        state_q      <= S_WAIT_TX;
                    end
`endif
                    S_DONE: begin
                        if (!pool_done) begin
                            done_q  <= 1'b0;
                            addr_q  <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign infer_addr  = addr_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign stream_busy = busy_q;
    assign stream_done = done_q;
    assign byte_count  = count_q;

endmodule

// File: tb/tb_pool_result_streamer.sv
// Directed bench for pool_result_streamer: sync-read BRAM model (data = addr[7:0]) and a 10-cycle-busy UART TX model.
module tb_pool_result_streamer;

    localparam int OUTSIZE = 3969;
    localparam int AW      = 16;
    localparam int RD_LAT  = 2;
`ifdef STREAM_CHECKSUM_EN
    localparam int FRAME = OUTSIZE + 1;
`else
    localparam int FRAME = OUTSIZE;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          pool_done;
    logic [AW-1:0] infer_addr;
    logic [7:0]    infer_dout;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          stream_busy;
    logic          stream_done;
    logic [AW-1:0] byte_count;

    logic          stall;
    int            busy_cnt = 0;
    logic [AW-1:0] addr_r = '0;
    logic [7:0]    rx_q[$];
    logic          prev_start = 1'b0;
    int            dbl = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    pool_result_streamer #(.OUTSIZE(OUTSIZE), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .pool_done  (pool_done),
        .infer_addr (infer_addr),
        .infer_dout (infer_dout),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .stream_busy(stream_busy),
        .stream_done(stream_done),
        .byte_count (byte_count)
    );

    // BRAM with a registered address: data for an address is sampleable RD_LAT edges after it is driven.
    always @(posedge clk) addr_r <= infer_addr;
    assign infer_dout = addr_r[7:0];

    always @(posedge clk) begin
        if (tx_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = stall || (busy_cnt != 0);

    always @(negedge clk) begin
        if (tx_start) begin
            rx_q.push_back(tx_data);
            if (prev_start) dbl++;
        end
        prev_start = tx_start;
    end

    wire any_out = tx_start | (|tx_data) | stream_busy | stream_done | (|byte_count) | (|infer_addr);

    function automatic int pulses();
        return rx_q.size();
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int cyc = 0;
        while (pulses() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(pulses() >= n), 32'd1);
    endtask

    task automatic wait_busy(input logic level, input int budget, input string tag);
        int cyc = 0;
        while (tx_busy !== level && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(tx_busy), 32'(level));
    endtask

    initial begin
        int base;
        int p0;
        int nz;
        int bad;
        int cyc;
        logic [7:0] e;
        logic [7:0] csum;

        reset = 1'b1;
        pool_done = 1'b0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(any_out), 32'd0);
        reset = 1'b0;

        // Idle with pool_done low: nothing may move.
        p0 = pulses();
        nz = 0;
        repeat (100) begin
            @(negedge clk);
            if (any_out !== 1'b0) nz++;
        end
        check("idle_quiet_cycles", nz, 0);
        check("idle_no_start", pulses() - p0, 0);

        // Full frame, with a 500-cycle busy stall while byte 5 is on the line.
        base = pulses();
        pool_done = 1'b1;
        wait_pulses(base + 6, 200, "byte5_timeout");
        check("byte5_data", tx_data, 8'h05);
        stall = 1'b1;
        repeat (500) @(negedge clk);
        check("stall_no_start", pulses() - base, 6);
        check("stall_hold_data", tx_data, 8'h05);
        stall = 1'b0;
        wait_pulses(base + 7, 100, "byte6_timeout");
        check("byte6_data", rx_q[base + 6], 8'h06);

        cyc = 0;
        while (stream_done !== 1'b1 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
        end
        check("frame_done_timeout", 32'(stream_done), 32'd1);
        check("frame_pulses", pulses() - base, FRAME);
        bad = 0;
        csum = 8'h00;
        for (int i = 0; i < OUTSIZE; i++) begin
            e = i[7:0];
            csum ^= e;
            if (base + i < pulses() && rx_q[base + i] !== e) bad++;
        end
        check("frame_data_errors", bad, 0);
        check("last_pixel", rx_q[base + OUTSIZE - 1], 8'h80);
`ifdef STREAM_CHECKSUM_EN
        check("checksum_byte", rx_q[base + OUTSIZE], csum);
        check("checksum_value", rx_q[base + OUTSIZE], 8'h80);
`endif
        check("frame_byte_count", byte_count, FRAME);
        check("frame_stream_busy", 32'(stream_busy), 32'd0);
        check("frame_addr_hold", infer_addr, OUTSIZE - 1);
        repeat (50) @(negedge clk);
        check("no_resend", pulses() - base, FRAME);
        check("still_done", 32'(stream_done), 32'd1);
        check("single_cycle_pulses", dbl, 0);

        // Falling pool_done in DONE returns to IDLE.
        pool_done = 1'b0;
        repeat (2) @(negedge clk);
        check("done_to_idle", 32'(stream_done), 32'd0);
        check("idle_addr_zero", infer_addr, 0);

        // Abort after byte 100.
        base = pulses();
        pool_done = 1'b1;
        wait_pulses(base + 100, 3000, "byte100_timeout");
        pool_done = 1'b0;
        repeat (50) @(negedge clk);
        check("abort_no_start", pulses() - base, 100);
        check("abort_last_byte", rx_q[base + 99], 8'h63);
        check("abort_stream_busy", 32'(stream_busy), 32'd0);
        check("abort_byte_count", byte_count, 100);
        check("abort_addr_zero", infer_addr, 0);

        base = pulses();
        pool_done = 1'b1;
        wait_pulses(base + 1, 100, "restart_timeout");
        check("restart_data", rx_q[base], 8'h00);
        check("restart_byte_count", byte_count, 1);

        // Reset lands in the WAIT_TX cycle of byte 3 with tx_busy low.
        wait_pulses(base + 3, 200, "pre_reset_timeout");
        wait_busy(1'b1, 20, "busy_rise_timeout");
        wait_busy(1'b0, 20, "busy_fall_timeout");
        repeat (4) @(negedge clk);
        p0 = pulses();
        reset = 1'b1;
        @(negedge clk);
        check("reset_tx_start", 32'(tx_start), 32'd0);
        check("reset_outputs_mid", 32'(any_out), 32'd0);
        check("reset_no_pulse", pulses() - p0, 0);
        pool_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("post_reset_quiet", pulses() - p0, 0);
        pool_done = 1'b1;
        wait_pulses(p0 + 1, 100, "post_reset_timeout");
        check("post_reset_data", rx_q[p0], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
